// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 matrix keypad
//                scanner: FSM state encoding, matrix dimensions, the row
//                drive pattern out of reset and small helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    // Row 0 driven low out of reset.
    localparam logic [KP_ROWS-1:0] KP_ROW_RESET = 4'b1110;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    // Index of the lowest-numbered column reading low (0 when none is low).
    function automatic logic [1:0] kp_lowest_low(input logic [KP_COLS-1:0] cols_n);
        kp_lowest_low = 2'd0;
        for (int i = KP_COLS - 1; i >= 0; i--) begin
            if (!cols_n[i]) begin
                kp_lowest_low = 2'(i);
            end
        end
    endfunction

    // Active-low one-hot row drive for a row index.
    function automatic logic [KP_ROWS-1:0] kp_row_drive(input logic [1:0] row);
        kp_row_drive = ~(KP_ROWS'(1) << row);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_sync
//  Description : Two-flop synchronizer for the asynchronous, active-low
//                column inputs. Resets to all ones (no key seen).
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk     in   system clock, rising edge
//    rst_n   in   asynchronous active-low reset
//    d_async in   WIDTH  raw column levels from the pins
//    q       out  WIDTH  synchronized column levels
// ============================================================================
module keypad_sync
    import keypad_pkg::*;
#(
    parameter int WIDTH = KP_COLS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_async,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d_async;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner. Drives one row low at a time,
//                samples the synchronized columns once per scan period,
//                debounces press and release, and presents the accepted key
//                on a valid/ready interface.
//  Revision    : 1.0 - initial release
//
//  Configuration macro
//    KEYPAD_SHIFT_EN  when defined, every accepted key is shifted into the
//                     16-bit data_out accumulator; otherwise data_out is 0.
//
//  Parameters
//    SCAN_DIV   clk cycles per row before its columns are sampled (>= 4)
//    DEBOUNCE   identical samples needed to accept a press/release (>= 1)
//
//  Ports
//    clk        in   system clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    cols_n     in   4   column inputs, active-low, asynchronous
//    rows_n     out  4   row drive, active-low, at most one bit low
//    key_code   out  4   accepted key {row, col}
//    key_valid  out  1   key_code holds an unaccepted key
//    key_ready  in   1   consumer takes key_code when high with key_valid
//    data_out   out  16  hex-entry accumulator
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [KP_COLS-1:0]  cols_n,
    output logic [KP_ROWS-1:0]  rows_n,
    output logic [3:0]          key_code,
    output logic                key_valid,
    input  logic                key_ready,
    output logic [15:0]         data_out
);

    localparam int              PS_W      = $clog2(SCAN_DIV);
    localparam int              DB_W      = $clog2(DEBOUNCE + 1);
    localparam logic [PS_W-1:0] PS_LAST   = PS_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0] DB_TARGET = DB_W'(DEBOUNCE);

    logic [KP_COLS-1:0] w_cols_sync;
    logic [PS_W-1:0]    r_prescale;
    logic               w_sample;
    kp_state_t          r_state;
    logic [1:0]         r_row;
    logic [1:0]         r_col;
    logic [DB_W-1:0]    r_db_cnt;
    logic [DB_W-1:0]    w_db_next;
    logic [1:0]         w_row_next;
    logic [1:0]         w_low_col;
    logic               w_all_high;
    logic               w_handshake;

    // ------------------------------------------------------------------
    // Column synchronizer
    // ------------------------------------------------------------------
    keypad_sync #(
        .WIDTH   (KP_COLS)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_async (cols_n),
        .q       (w_cols_sync)
    );

    // ------------------------------------------------------------------
    // Scan prescaler: one sample strobe every SCAN_DIV cycles
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else if (r_prescale == PS_LAST) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PS_W'(1);
        end
    end

    assign w_sample    = (r_prescale == PS_LAST);
    assign w_all_high  = &w_cols_sync;
    assign w_low_col   = kp_lowest_low(w_cols_sync);
    assign w_db_next   = r_db_cnt + DB_W'(1);
    assign w_row_next  = r_row + 2'd1;
    assign w_handshake = key_valid && key_ready;

    // ------------------------------------------------------------------
    // Scan / debounce FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_SCAN;
            r_row     <= 2'd0;
            r_col     <= 2'd0;
            r_db_cnt  <= '0;
            rows_n    <= KP_ROW_RESET;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SCAN: begin
                    if (w_sample) begin
                        if (w_all_high) begin
                            r_row  <= w_row_next;
                            rows_n <= kp_row_drive(w_row_next);
                        end else begin
                            // Row stays driven so the same key can be re-sampled.
                            r_col    <= w_low_col;
                            r_db_cnt <= DB_W'(1);
                            if (DB_W'(1) == DB_TARGET) begin
                                key_code <= {r_row, w_low_col};
                                r_state  <= ST_PRESSED;
                            end else begin
                                r_state  <= ST_DEBOUNCE;
                            end
                        end
                    end
                end

                ST_DEBOUNCE: begin
                    if (w_sample) begin
                        if (!w_cols_sync[r_col]) begin
                            r_db_cnt <= w_db_next;
                            if (w_db_next == DB_TARGET) begin
                                key_code <= {r_row, r_col};
                                r_state  <= ST_PRESSED;
                            end
                        end else begin
                            r_db_cnt <= '0;
                            r_row    <= w_row_next;
                            rows_n   <= kp_row_drive(w_row_next);
                            r_state  <= ST_SCAN;
                        end
                    end
                end

                ST_PRESSED: begin
                    // key_valid rises the cycle after key_code loads and is
                    // held regardless of the key until the consumer takes it.
                    if (!key_valid) begin
                        key_valid <= 1'b1;
                    end else if (w_handshake) begin
                        key_valid <= 1'b0;
                        r_db_cnt  <= '0;
                        r_state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (w_sample) begin
                        if (w_all_high) begin
                            if (w_db_next >= DB_TARGET) begin
                                r_db_cnt <= '0;
                                r_row    <= w_row_next;
                                rows_n   <= kp_row_drive(w_row_next);
                                r_state  <= ST_SCAN;
                            end else begin
                                r_db_cnt <= w_db_next;
                            end
                        end else begin
                            r_db_cnt <= '0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Hex-entry accumulator
    // ------------------------------------------------------------------
`ifdef KEYPAD_SHIFT_EN
    logic [15:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= 16'h0000;
        end else if (w_handshake) begin
            r_data <= {r_data[11:0], key_code};
        end
    end

    assign data_out = r_data;
`else
    assign data_out = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Directed self-checking bench for keypad_scanner with
//                SCAN_DIV=4 and DEBOUNCE=2. A behavioural key matrix drives
//                cols_n from rows_n; expected key codes are queued when a
//                press is driven and popped when key_valid is seen.
//                Honours KEYPAD_SHIFT_EN for the data_out expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  cols_n;
    logic [3:0]  rows_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] data_out;

    // Behavioural keypad: one held key plus an independent col-0 glitch.
    logic        key_down = 1'b0;
    logic [1:0]  key_row  = 2'd0;
    logic [1:0]  key_col  = 2'd0;
    logic        glitch   = 1'b0;
    logic [3:0]  w_key_cols;

    assign w_key_cols = (key_down && (rows_n[key_row] == 1'b0)) ? ~(4'b0001 << key_col) : 4'hF;
    assign cols_n     = w_key_cols & (glitch ? 4'b1110 : 4'b1111);

    int          checks = 0;
    int          passed = 0;
    int          failed = 0;
    logic [3:0]  exp_q[$];
    logic [15:0] data_model = 16'h0000;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEBOUNCE  (DEBOUNCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cols_n    (cols_n),
        .rows_n    (rows_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << row);
    endfunction

    task automatic wait_valid(input int max_cycles, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!ok) begin
                @(negedge clk);
                ok = key_valid;
            end
        end
    endtask

    task automatic wait_rows_change(input int max_cycles, output logic ok);
        logic [3:0] start;
        start = rows_n;
        ok    = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!ok) begin
                @(negedge clk);
                ok = (rows_n != start);
            end
        end
    endtask

    // Press a key with key_ready high, check the handshake, release it and
    // check the scan resumes on the following row.
    task automatic accept_key(input logic [3:0] code);
        logic       ok;
        logic [3:0] exp;
        logic [1:0] nrow;
        key_row   = code[3:2];
        key_col   = code[1:0];
        key_ready = 1'b1;
        key_down  = 1'b1;
        exp_q.push_back(code);
        wait_valid(300, ok);
        check("accept_seen", {15'd0, ok}, 16'd1);
        if (ok) begin
            exp = exp_q.pop_front();
            check("accept_code", {12'd0, key_code}, {12'd0, exp});
`ifdef KEYPAD_SHIFT_EN
            data_model = {data_model[11:0], exp};
`endif
            @(negedge clk);
            check("accept_valid_drop", {15'd0, key_valid}, 16'd0);
            check("accept_data", data_out, data_model);
            repeat (12) @(negedge clk);
            check("accept_row_frozen", {12'd0, rows_n}, {12'd0, row_drive(code[3:2])});
        end else begin
            exp_q.delete();
        end
        key_down = 1'b0;
        wait_rows_change(100, ok);
        check("accept_resume_seen", {15'd0, ok}, 16'd1);
        nrow = code[3:2] + 2'd1;
        check("accept_resume_row", {12'd0, rows_n}, {12'd0, row_drive(nrow)});
    endtask

    initial begin
        logic       ok;
        logic       valid_seen;
        logic [3:0] exp;
        logic [3:0] exp_row;
        int         hold_cnt;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rows", {12'd0, rows_n}, 16'h000E);
        check("rst_valid", {15'd0, key_valid}, 16'd0);
        check("rst_code", {12'd0, key_code}, 16'd0);
        check("rst_data", data_out, 16'h0000);
        rst_n = 1'b1;

        // ---------------- idle scan: 4 clocks per row ----------------
        valid_seen = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            valid_seen = valid_seen | key_valid;
            exp_row    = row_drive(2'((k / 4) % 4));
            check("idle_rows", {12'd0, rows_n}, {12'd0, exp_row});
        end
        check("idle_no_valid", {15'd0, valid_seen}, 16'd0);

        // ---------------- row 2 / col 1, ready held high ----------------
        accept_key(4'h9);

        // ---------------- single-sample glitch on row 0 col 0 ----------------
        wait_rows_change(100, ok);
        while (ok && rows_n != 4'b1110) wait_rows_change(100, ok);
        check("glitch_row0_reached", {15'd0, ok}, 16'd1);
        glitch = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b0;
        check("glitch_sampled_freeze", {12'd0, rows_n}, 16'h000E);
        valid_seen = 1'b0;
        ok         = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!ok) begin
                @(negedge clk);
                valid_seen = valid_seen | key_valid;
                ok         = (rows_n != 4'b1110);
            end
        end
        check("glitch_no_valid", {15'd0, valid_seen}, 16'd0);
        check("glitch_scan_row1", {12'd0, rows_n}, 16'h000D);

        // ---------------- key 5, ready withheld, released while waiting ----
        key_ready = 1'b0;
        key_row   = 2'd1;
        key_col   = 2'd1;
        key_down  = 1'b1;
        exp_q.push_back(4'h5);
        wait_valid(300, ok);
        check("k5_seen", {15'd0, ok}, 16'd1);
        exp = exp_q.pop_front();
        check("k5_code", {12'd0, key_code}, {12'd0, exp});
        key_down = 1'b0;
        hold_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (key_valid && key_code == 4'h5) hold_cnt++;
        end
        check("k5_hold", 16'(hold_cnt), 16'd50);
        key_ready = 1'b1;
`ifdef KEYPAD_SHIFT_EN
        data_model = {data_model[11:0], exp};
`endif
        @(negedge clk);
        check("k5_valid_drop", {15'd0, key_valid}, 16'd0);
        check("k5_data", data_out, data_model);
        wait_rows_change(100, ok);
        check("k5_resume_row2", {12'd0, rows_n}, 16'h000B);

        // ---------------- accumulator: 1,2,3,4 then A ----------------
        accept_key(4'h1);
        accept_key(4'h2);
        accept_key(4'h3);
        accept_key(4'h4);
`ifdef KEYPAD_SHIFT_EN
        check("data_1234", data_out, 16'h1234);
`else
        check("data_1234", data_out, 16'h0000);
`endif
        accept_key(4'hA);
`ifdef KEYPAD_SHIFT_EN
        check("data_234A", data_out, 16'h234A);
`else
        check("data_234A", data_out, 16'h0000);
`endif

        // ---------------- asynchronous reset during PRESSED ----------------
        key_ready = 1'b0;
        key_row   = 2'd1;
        key_col   = 2'd2;
        key_down  = 1'b1;
        exp_q.push_back(4'h6);
        wait_valid(300, ok);
        check("k6_seen", {15'd0, ok}, 16'd1);
        exp = exp_q.pop_front();
        check("k6_code", {12'd0, key_code}, {12'd0, exp});
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {15'd0, key_valid}, 16'd0);
        check("arst_rows", {12'd0, rows_n}, 16'h000E);
        check("arst_data", data_out, 16'h0000);
        data_model = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;

        // Held key is detected again as a fresh press.
        key_ready = 1'b1;
        exp_q.push_back(4'h6);
        wait_valid(300, ok);
        check("k6_redetect_seen", {15'd0, ok}, 16'd1);
        exp = exp_q.pop_front();
        check("k6_redetect_code", {12'd0, key_code}, {12'd0, exp});
`ifdef KEYPAD_SHIFT_EN
        data_model = {data_model[11:0], exp};
`endif
        @(negedge clk);
        check("k6_redetect_drop", {15'd0, key_valid}, 16'd0);
        check("k6_redetect_data", data_out, data_model);
        key_down = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
